// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bp_pkg
// Purpose  : Shared types and constants for the dynamic branch predictor.
// Revision : 1.0 - initial release
// ============================================================================
package bp_pkg;

  // Widest tag a 32-bit PC can ever supply; entries store the tag
  // zero-extended to this width so the struct is independent of TAG_W.
  localparam int BP_TAG_MAX = 30;

  // 2-bit saturating direction counter; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_ctr_t;

  // RV32 control-flow opcodes, for decode logic upstream of the predictor.
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // One BTB entry.
  typedef struct packed {
    logic                  valid;
    logic [BP_TAG_MAX-1:0] tag;
    bp_ctr_t               ctr;
    logic [31:0]           target;
  } bp_entry_t;

  // Sequential fall-through address.
  function automatic logic [31:0] bp_next_seq(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bp_ctr_update.sv
`default_nettype none
// ============================================================================
// Module   : bp_ctr_update
// Purpose  : Saturating next-state for a 2-bit direction counter.
// Revision : 1.0 - initial release
// ============================================================================
module bp_ctr_update
  import bp_pkg::*;
(
  input  bp_ctr_t i_ctr,
  input  logic    i_taken,
  output bp_ctr_t o_ctr
);

  // Step one state toward the resolved direction, holding at the ends.
  always_comb begin
    o_ctr = i_ctr;
    case (i_ctr)
      SNT:     o_ctr = i_taken ? WNT : SNT;
      WNT:     o_ctr = i_taken ? WT  : SNT;
      WT:      o_ctr = i_taken ? ST  : WNT;
      ST:      o_ctr = i_taken ? ST  : WT;
      default: o_ctr = i_ctr;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Purpose  : Direct-mapped BTB with 2-bit counters. Predicts next PC in
//            Fetch, resolves and trains in Execute, raises flush/redirect.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc_f,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_pc,
  input  logic        i_ex_valid,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_is_branch,
  input  logic        i_ex_is_jump,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_pc,
  output logic        o_mispredict,
  output logic [31:0] o_redirect_pc,
  output logic [31:0] o_br_count,
  output logic [31:0] o_mispred_count
);

  localparam int        c_ENTRIES   = 1 << IDX_W;
  localparam int        c_TAG_LO    = IDX_W + 2;
  localparam int        c_TAG_HI    = IDX_W + TAG_W + 1;
  localparam bp_entry_t c_ENTRY_RST = '{valid: 1'b0, tag: '0, ctr: WNT, target: '0};

  bp_entry_t r_table [c_ENTRIES];
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  // Fetch-side lookup
  logic [IDX_W-1:0]      w_f_idx;
  logic [BP_TAG_MAX-1:0] w_f_tag;
  bp_entry_t             w_f_entry;
  logic                  w_f_hit;

  // Execute-side lookup and resolution
  logic [IDX_W-1:0]      w_ex_idx;
  logic [BP_TAG_MAX-1:0] w_ex_tag;
  bp_entry_t             w_ex_entry;
  logic                  w_ex_hit;
  logic                  w_ex_ctrl;
  logic [31:0]           w_actual_pc;
  bp_ctr_t               w_ctr_next;

  // Training write
  logic                  w_wr_en;
  bp_entry_t             w_wr_entry;

  // PC bits that take no part in indexing or tagging
  logic                  w_unused_bits;

  assign w_f_idx   = i_pc_f[IDX_W+1:2];
  assign w_f_tag   = BP_TAG_MAX'(i_pc_f[c_TAG_HI:c_TAG_LO]);
  assign w_f_entry = r_table[w_f_idx];
  assign w_f_hit   = w_f_entry.valid && (w_f_entry.tag == w_f_tag);

  assign o_pred_taken = w_f_hit && w_f_entry.ctr[1];
  assign o_pred_pc    = o_pred_taken ? w_f_entry.target : bp_next_seq(i_pc_f);

  assign w_ex_idx   = i_ex_pc[IDX_W+1:2];
  assign w_ex_tag   = BP_TAG_MAX'(i_ex_pc[c_TAG_HI:c_TAG_LO]);
  assign w_ex_entry = r_table[w_ex_idx];
  assign w_ex_hit   = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);
  assign w_ex_ctrl  = i_ex_is_branch || i_ex_is_jump;

  assign w_actual_pc   = (w_ex_ctrl && i_ex_taken) ? i_ex_target : bp_next_seq(i_ex_pc);
  // Any disagreement with the carried prediction flushes, including a stale
  // alias that sent a non-control instruction down a taken path.
  assign o_mispredict  = !i_rst && i_ex_valid && (w_actual_pc != i_ex_pred_pc);
  assign o_redirect_pc = w_actual_pc;

  assign o_br_count      = r_br_count;
  assign o_mispred_count = r_mispred_count;

  assign w_unused_bits = ^{i_pc_f[31:c_TAG_HI+1], i_pc_f[1:0],
                           i_ex_pc[31:c_TAG_HI+1], i_ex_pc[1:0], i_ex_pred_taken};

  bp_ctr_update u_ctr_update (
    .i_ctr   (w_ex_entry.ctr),
    .i_taken (i_ex_taken),
    .o_ctr   (w_ctr_next)
  );

  // Decide whether and what to write back into the Execute instruction's entry.
  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_entry = w_ex_entry;
    if (i_ex_valid) begin
      if (i_ex_is_jump) begin
        // Jumps are always taken: allocate or overwrite as strongly taken.
        w_wr_en    = 1'b1;
        w_wr_entry = '{valid: 1'b1, tag: w_ex_tag, ctr: ST, target: i_ex_target};
      end else if (i_ex_is_branch) begin
        if (w_ex_hit) begin
          w_wr_en        = 1'b1;
          w_wr_entry.ctr = w_ctr_next;
          if (i_ex_taken) begin
            w_wr_entry.target = i_ex_target;
          end
        end else if (i_ex_taken) begin
          // Only taken branches earn a slot; not-taken misses predict fine as-is.
          w_wr_en    = 1'b1;
          w_wr_entry = '{valid: 1'b1, tag: w_ex_tag, ctr: WT, target: i_ex_target};
        end
      end else if (w_ex_hit && w_ex_entry.ctr[1]) begin
        // Non-control instruction aliasing a taken entry: drop the entry.
        w_wr_en          = 1'b1;
        w_wr_entry.valid = 1'b0;
      end
    end
  end

  // BTB storage: reset clears every entry and overrides any training write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < c_ENTRIES; i++) begin
        r_table[i] <= c_ENTRY_RST;
      end
    end else if (w_wr_en) begin
      r_table[w_ex_idx] <= w_wr_entry;
    end
  end

  // Performance counters, free-running and wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_br_count      <= '0;
      r_mispred_count <= '0;
    end else begin
      if (i_ex_valid && w_ex_ctrl) begin
        r_br_count <= r_br_count + 32'd1;
      end
      if (o_mispredict) begin
        r_mispred_count <= r_mispred_count + 32'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predictor
// Purpose  : Directed plus randomized bench for branch_predictor against a
//            behavioural BTB model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_f;
  logic        pred_taken;
  logic [31:0] pred_pc;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_br;
  logic        ex_jmp;
  logic        ex_tk;
  logic [31:0] ex_tgt;
  logic        ex_ptk;
  logic [31:0] ex_ppc;
  logic        misp;
  logic [31:0] redir;
  logic [31:0] br_cnt;
  logic [31:0] mp_cnt;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_W(6), .TAG_W(8)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_pc_f          (pc_f),
    .o_pred_taken    (pred_taken),
    .o_pred_pc       (pred_pc),
    .i_ex_valid      (ex_valid),
    .i_ex_pc         (ex_pc),
    .i_ex_is_branch  (ex_br),
    .i_ex_is_jump    (ex_jmp),
    .i_ex_taken      (ex_tk),
    .i_ex_target     (ex_tgt),
    .i_ex_pred_taken (ex_ptk),
    .i_ex_pred_pc    (ex_ppc),
    .o_mispredict    (misp),
    .o_redirect_pc   (redir),
    .o_br_count      (br_cnt),
    .o_mispred_count (mp_cnt)
  );

  // Behavioural model: 64 entries, counters as plain integers 0..3.
  bit          m_valid [64];
  bit   [7:0]  m_tag   [64];
  int          m_ctr   [64];
  bit   [31:0] m_tgt   [64];
  int unsigned m_br;
  int unsigned m_mp;

  int n_vec = 0;
  int n_err = 0;

  // Outputs observed during the most recent step.
  logic        l_pt, l_misp;
  logic [31:0] l_pp, l_redir, l_br, l_mp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = 8'd0;
      m_ctr[i]   = 1;
      m_tgt[i]   = 32'd0;
    end
    m_br = 0;
    m_mp = 0;
  endtask

  function automatic logic [31:0] model_pred(input logic [31:0] pc);
    int  i;
    bit  hit;
    i   = int'(pc[7:2]);
    hit = m_valid[i] && (m_tag[i] == pc[15:8]);
    return (hit && m_ctr[i] >= 2) ? m_tgt[i] : pc + 32'd4;
  endfunction

  // Apply one cycle of stimulus, check outputs mid-cycle, then advance the model.
  task automatic step(input logic r, input logic [31:0] pcf, input logic v,
                      input logic [31:0] epc, input logic br, input logic jmp,
                      input logic tk, input logic [31:0] tgt, input logic [31:0] ppc);
    logic [31:0] e_pp, act;
    logic        e_pt, e_misp, ctrl, hit;
    int          fi, ei;
    rst = r; pc_f = pcf; ex_valid = v; ex_pc = epc; ex_br = br; ex_jmp = jmp;
    ex_tk = tk; ex_tgt = tgt; ex_ppc = ppc; ex_ptk = (ppc != epc + 32'd4);
    @(negedge clk);
    fi     = int'(pcf[7:2]);
    e_pt   = m_valid[fi] && (m_tag[fi] == pcf[15:8]) && (m_ctr[fi] >= 2);
    e_pp   = model_pred(pcf);
    ctrl   = br | jmp;
    act    = (ctrl && tk) ? tgt : epc + 32'd4;
    e_misp = !r && v && (act != ppc);
    l_pt = pred_taken; l_pp = pred_pc; l_misp = misp; l_redir = redir;
    l_br = br_cnt; l_mp = mp_cnt;
    if (!r) begin
      chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_pt});
      chk("pred_pc", pred_pc, e_pp);
    end
    chk("mispredict", {31'd0, misp}, {31'd0, e_misp});
    chk("redirect_pc", redir, act);
    chk("br_count", br_cnt, m_br);
    chk("mispred_count", mp_cnt, m_mp);
    // Model update at the clock edge
    if (r) begin
      model_clear();
    end else if (v) begin
      ei  = int'(epc[7:2]);
      hit = m_valid[ei] && (m_tag[ei] == epc[15:8]);
      if (ctrl) m_br++;
      if (e_misp) m_mp++;
      if (jmp) begin
        m_valid[ei] = 1'b1; m_tag[ei] = epc[15:8]; m_ctr[ei] = 3; m_tgt[ei] = tgt;
      end else if (br) begin
        if (hit) begin
          m_ctr[ei] = tk ? ((m_ctr[ei] == 3) ? 3 : m_ctr[ei] + 1)
                         : ((m_ctr[ei] == 0) ? 0 : m_ctr[ei] - 1);
          if (tk) m_tgt[ei] = tgt;
        end else if (tk) begin
          m_valid[ei] = 1'b1; m_tag[ei] = epc[15:8]; m_ctr[ei] = 2; m_tgt[ei] = tgt;
        end
      end else if (hit && m_ctr[ei] >= 2) begin
        m_valid[ei] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rpc, rpcf, rtgt, rppc;
    logic        rbr, rjmp, rtk, rv, rr;
    int          kind, sel;

    rst = 1'b1; pc_f = 32'h100; ex_valid = 1'b0; ex_pc = '0; ex_br = 1'b0;
    ex_jmp = 1'b0; ex_tk = 1'b0; ex_tgt = '0; ex_ptk = 1'b0; ex_ppc = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;

    // Reset cycle with a would-be training write: suppressed mispredict.
    step(1, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 32'h104);
    chk("rst_misp", {31'd0, l_misp}, 32'd0);

    // Cold lookup
    step(0, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0, 32'h4);
    chk("cold_pt", {31'd0, l_pt}, 32'd0);
    chk("cold_pp", l_pp, 32'h104);
    chk("cold_br", l_br, 32'd0);
    chk("cold_mp", l_mp, 32'd0);

    // Taken beq on cold table
    step(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 32'h104);
    chk("beq_misp", {31'd0, l_misp}, 32'd1);
    chk("beq_redir", l_redir, 32'h80);
    step(0, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0, 32'h4);
    chk("beq_pt", {31'd0, l_pt}, 32'd1);
    chk("beq_pp", l_pp, 32'h80);

    // Not-taken three times; fetch of same index sees pre-update prediction.
    step(0, 32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 32'h80);
    chk("nt1_misp", {31'd0, l_misp}, 32'd1);
    chk("nt1_redir", l_redir, 32'h104);
    chk("collide_pp", l_pp, 32'h80);
    step(0, 32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 32'h104);
    chk("nt2_misp", {31'd0, l_misp}, 32'd0);
    step(0, 32'h100, 1, 32'h100, 1, 0, 0, 32'h80, 32'h104);
    step(0, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0, 32'h4);
    chk("sat_pp", l_pp, 32'h104);
    // From saturated SNT one taken gives WNT: still predicts not taken.
    step(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 32'h104);
    step(0, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0, 32'h4);
    chk("sat_up_pt", {31'd0, l_pt}, 32'd0);

    // jal at 0x200 -> 0x400
    step(0, 32'h200, 1, 32'h200, 0, 1, 1, 32'h400, 32'h204);
    chk("jal1_misp", {31'd0, l_misp}, 32'd1);
    step(0, 32'h200, 1, 32'h200, 0, 1, 1, 32'h400, 32'h400);
    chk("jal_pp", l_pp, 32'h400);
    chk("jal2_misp", {31'd0, l_misp}, 32'd0);
    step(0, 32'h300, 0, 32'h0, 0, 0, 0, 32'h0, 32'h4);
    chk("jal_br_cnt", l_br, 32'd7);

    // Aliasing: make 0x100 taken, then a non-control op at 0x100
    step(0, 32'h300, 1, 32'h100, 1, 0, 1, 32'h80, 32'h104);
    step(0, 32'h100, 1, 32'h100, 0, 0, 0, 32'h0, 32'h80);
    chk("alias_pt_before", {31'd0, l_pt}, 32'd1);
    chk("alias_misp", {31'd0, l_misp}, 32'd1);
    chk("alias_redir", l_redir, 32'h104);
    step(0, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0, 32'h4);
    chk("alias_inval_pt", {31'd0, l_pt}, 32'd0);

    // Re-allocate, then reset in the same cycle as another training write.
    step(0, 32'h100, 1, 32'h100, 1, 0, 1, 32'h80, 32'h104);
    step(1, 32'h100, 1, 32'h100, 1, 0, 1, 32'h90, 32'h104);
    chk("rst2_misp", {31'd0, l_misp}, 32'd0);
    step(0, 32'h100, 0, 32'h0, 0, 0, 0, 32'h0, 32'h4);
    chk("rst2_pt", {31'd0, l_pt}, 32'd0);
    chk("rst2_br", l_br, 32'd0);

    // Randomized traffic over a small PC footprint to force hits and aliases.
    for (int n = 0; n < 400; n++) begin
      rpc  = {16'd0, 6'd0, 2'($urandom_range(0, 3)), 4'd0, 2'($urandom_range(0, 3)), 2'b00};
      rpcf = {16'd0, 6'd0, 2'($urandom_range(0, 3)), 4'd0, 2'($urandom_range(0, 3)), 2'b00};
      rtgt = {16'd0, 14'($urandom), 2'b00};
      kind = int'($urandom_range(0, 9));
      rbr  = (kind < 5);
      rjmp = (kind == 5 || kind == 6);
      rtk  = rjmp ? 1'b1 : 1'($urandom);
      rv   = ($urandom_range(0, 9) != 0);
      rr   = ($urandom_range(0, 59) == 0);
      sel  = int'($urandom_range(0, 9));
      rppc = (sel < 6) ? model_pred(rpc) : (sel < 8) ? rpc + 32'd4 : rtgt;
      step(rr, rpcf, rv, rpc, rbr, rjmp, rtk, rtgt, rppc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Hard time bound so the run can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic branch predictor and redirect controller for the 5-stage pipeline.
- In Fetch, it looks up the fetch PC in a direct-mapped BTB holding 2-bit saturating counters, and produces a predicted next PC.
- In Execute, it compares the resolved outcome from the ALU (is_branch, is_jump, o_br_sel_final, target) against the prediction carried down the pipe. It trains the table and raises the mispredict flush/redirect.

Parameters:
- IDX_W, 6, BTB index width; 2^IDX_W entries.
- TAG_W, 8, tag bits stored per entry.

Ports:
- i_clk  in  1  core clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_pc_f  in  32  Fetch-stage PC.
- o_pred_taken  out  1  Fetch prediction: taken.
- o_pred_pc  out  32  predicted next PC: BTB target if taken, else i_pc_f+4.
- i_ex_valid  in  1  Execute-stage slot holds a real instruction (0 for bubble/flush).
- i_ex_pc  in  32  PC of the Execute instruction.
- i_ex_is_branch  in  1  conditional branch in Execute (ALU is_branch).
- i_ex_is_jump  in  1  jal/jalr in Execute (ALU is_jump).
- i_ex_taken  in  1  resolved direction (ALU o_br_sel_final).
- i_ex_target  in  32  resolved target (ALU result).
- i_ex_pred_taken  in  1  prediction made for this instruction in Fetch, pipelined.
- i_ex_pred_pc  in  32  predicted next PC for this instruction, pipelined.
- o_mispredict  out  1  flush IF/ID and ID/EX this cycle.
- o_redirect_pc  out  32  correct next PC when o_mispredict=1.
- o_br_count  out  32  resolved control-flow instructions.
- o_mispred_count  out  32  mispredictions.

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset state:
  - All entry valid bits are 0.
  - All counters are 2'b01 (weakly not-taken).
  - o_br_count and o_mispred_count are 0.
  - Outputs during reset follow the combinational rules below against the cleared table: o_pred_taken=0, o_pred_pc=i_pc_f+4.
- Addressing:
  - idx = pc[IDX_W+1:2].
  - tag = pc[IDX_W+TAG_W+1:IDX_W+2].
  - An entry holds valid, tag, 2-bit counter and a 32-bit target.
- Prediction, combinational with zero latency:
  - hit = valid[idx] & (tag match).
  - o_pred_taken = hit & counter[1].
  - o_pred_pc = o_pred_taken ? target : i_pc_f+4.
- Resolution, combinational in the Execute cycle:
  - ctrl = i_ex_is_branch | i_ex_is_jump.
  - actual_pc = (ctrl & i_ex_taken) ? i_ex_target : i_ex_pc+4.
  - o_mispredict = i_ex_valid & (actual_pc != i_ex_pred_pc). A stale alias predicted taken on a non-control instruction is included.
  - o_redirect_pc = actual_pc. It is don't-care when o_mispredict=0 but is still driven with actual_pc.
- Training, registered on the clock edge when i_ex_valid=1:
  - Branch, tag hit: counter saturating inc if taken, dec if not. Taken: target <= i_ex_target.
  - Branch, tag miss, taken: allocate with valid=1, new tag, counter=2'b10, target.
  - Branch, tag miss, not taken: no write.
  - Jump: allocate or overwrite with counter=2'b11 and target=i_ex_target.
  - Non-control instruction with a hit entry predicted taken: clear valid.
  - Saturation: 2'b11+1 stays 2'b11; 2'b00-1 stays 2'b00.
- Perf counters:
  - o_br_count increments on i_ex_valid & ctrl.
  - o_mispred_count increments on o_mispredict.
  - Both wrap modulo 2^32.
- Read/write collision: when Fetch reads the index Execute writes in the same cycle, Fetch sees the pre-update contents. The new value is visible from the next cycle.
- i_ex_valid=0: no table write, no counter increment, o_mispredict=0.
- Reset mid-operation: i_rst wins over any same-cycle training write. o_mispredict is forced 0 during the i_rst cycle.

Decomposition:
- Package bp_pkg:
  - typedef enum logic[1:0] {SNT, WNT, WT, ST} bp_ctr_t.
  - Opcode constants OP_BRANCH=7'b1100011, OP_JAL=7'b1101111, OP_JALR=7'b1100111.
  - Entry struct bp_entry_t {valid, tag, ctr, target}.
- Sub-module bp_ctr_update (combinational saturating next-counter from current ctr and taken).

Test Plan:
- Reset, then i_pc_f=0x100 -> o_pred_taken=0, o_pred_pc=0x104; both perf counters 0.
- Taken beq at 0x100, target 0x80, on cold table -> o_mispredict=1, o_redirect_pc=0x80; next cycle lookup of 0x100 gives o_pred_taken=1 (ctr WT), o_pred_pc=0x80.
- Same branch resolved not-taken three times -> ctr WT->WNT->SNT->SNT (saturates); lookup gives o_pred_pc=0x104; first not-taken flags mispredict with redirect 0x104.
- jal at 0x200, target 0x400 -> entry ctr=ST; second execution with i_ex_pred_pc=0x400 -> o_mispredict=0, o_br_count increments.
- Aliasing: entry for 0x100 valid; non-control instruction at 0x100 with i_ex_pred_pc=0x80 -> o_mispredict=1, redirect 0x104, entry invalidated.
- Fetch of 0x100 in the same cycle as a training write to idx of 0x100 -> old prediction returned; i_rst asserted that cycle -> no write, table cleared, o_mispredict=0.
